// File: rtl/rf_port_arbiter.sv
// Write-port arbiter and reset-clear sequencer for the RV32I register file.
// Shares one write port between execute, load and debug, and lends read port 1 to debug reads.
module rf_port_arbiter #(
   parameter int XLEN           = 32,
   parameter int AW             = 5,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_we,
   input  logic [AW-1:0]   ex_rd,
   input  logic [XLEN-1:0] ex_data,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [AW-1:0]   ld_rd,
   input  logic [XLEN-1:0] ld_data,
   input  logic [AW-1:0]   core_rs1,
   input  logic [AW-1:0]   core_rs2,
   output logic            core_stall,
   input  logic            dbg_req,
   input  logic            dbg_we,
   input  logic [AW-1:0]   dbg_addr,
   input  logic [XLEN-1:0] dbg_wdata,
   output logic            dbg_ack,
   output logic [XLEN-1:0] dbg_rdata,
   output logic            rf_regWrite,
   output logic [AW-1:0]   rf_rd,
   output logic [XLEN-1:0] rf_data,
   output logic [AW-1:0]   rf_rs1,
   output logic [AW-1:0]   rf_rs2,
   input  logic [XLEN-1:0] rf_output1
);

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_RUN,
      ST_DBG
   } state_t;

   localparam state_t        RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
   localparam logic          RESET_STALL = CLEAR_ON_RESET;
   localparam logic [AW-1:0] FIRST_IDX   = AW'(1);
   localparam logic [AW-1:0] LAST_IDX    = '1;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] clr_idx;
   logic          wr_sel;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; combinational logic below uses blocking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RESET_STATE;
         clr_idx    <= FIRST_IDX;
         core_stall <= RESET_STALL;
         dbg_ack    <= 1'b0;
         dbg_rdata  <= '0;
      end else begin
         state      <= state_nxt;
         core_stall <= (state_nxt != ST_RUN);
         dbg_ack    <= (state == ST_DBG);
         if (state == ST_CLEAR) clr_idx <= clr_idx + AW'(1);
         if (state == ST_DBG && !dbg_we)
            dbg_rdata <= (dbg_addr == '0) ? '0 : rf_output1;
      end
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = state;
      wr_sel    = 1'b0;
      rf_rd     = '0;
      rf_data   = '0;
      ld_ready  = 1'b0;
      rf_rs1    = core_rs1;

      case (state)
         ST_CLEAR: begin
            wr_sel = 1'b1;
            rf_rd  = clr_idx;
            if (clr_idx == LAST_IDX) state_nxt = ST_RUN;
         end

         ST_RUN: begin
            // Execute wins; a write to x0 is not a write and never blocks the load.
            if (ex_we && ex_rd != '0) begin
               wr_sel  = 1'b1;
               rf_rd   = ex_rd;
               rf_data = ex_data;
            end else begin
               ld_ready = 1'b1;
               if (ld_valid && ld_rd != '0) begin
                  wr_sel  = 1'b1;
                  rf_rd   = ld_rd;
                  rf_data = ld_data;
               end
            end
            if (dbg_req && !dbg_ack) state_nxt = ST_DBG;
         end

         ST_DBG: begin
            state_nxt = ST_RUN;
            if (dbg_we) begin
               if (dbg_addr != '0) begin
                  wr_sel  = 1'b1;
                  rf_rd   = dbg_addr;
                  rf_data = dbg_wdata;
               end
            end else begin
               rf_rs1 = dbg_addr;
            end
         end

         default: state_nxt = RESET_STATE;
      endcase
   end

   // The reset state is CLEAR, so the write enable is gated to stay quiet while reset is held.
   assign rf_regWrite = wr_sel & rst_n;
   assign rf_rs2      = core_rs2;

endmodule
